// File: rtl/dmem_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : dmem_arbiter
// Purpose  : CPU/DMA data-memory arbiter with read-return steering and a
//            saturating conflict counter. Define DMEM_ARB_STARVE_EN to enable
//            DMA starvation promotion after MAX_WAIT denied cycles.
// Revision : 1.0 - initial release
// =============================================================================
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [DATA_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [15:0]           conflict_cnt
);

    localparam logic [15:0] c_CONFLICT_MAX = 16'hFFFF;

    logic        w_cpu_gnt;
    logic        w_dma_gnt;
    logic        w_promote;
    logic        r_rd_cpu;
    logic        r_rd_dma;
    logic [15:0] r_conflict_cnt;

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

    logic [7:0] r_wait_cnt;

    // DMA takes the port for one cycle once it has been denied MAX_WAIT times.
    assign w_promote = dma_req && (r_wait_cnt == c_MAX_WAIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= 8'd0;
        end else if (!dma_req || w_dma_gnt) begin
            r_wait_cnt <= 8'd0;
        end else if (r_wait_cnt != c_MAX_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end
`else
    assign w_promote = 1'b0;
`endif

    assign w_cpu_gnt = cpu_req && !w_promote;
    assign w_dma_gnt = dma_req && (w_promote || !cpu_req);

    assign cpu_gnt = w_cpu_gnt;
    assign dma_gnt = w_dma_gnt;

    always_comb begin
        mem_addr  = '0;
        mem_data  = '0;
        mem_write = 1'b0;
        if (w_cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_data  = cpu_wdata;
            mem_write = cpu_we;
        end else if (w_dma_gnt) begin
            mem_addr  = dma_addr;
            mem_data  = dma_wdata;
            mem_write = dma_we;
        end
    end

    // Read owner: the memory returns data one cycle after the granted read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_cpu <= 1'b0;
            r_rd_dma <= 1'b0;
        end else begin
            r_rd_cpu <= w_cpu_gnt && !cpu_we;
            r_rd_dma <= w_dma_gnt && !dma_we;
        end
    end

    assign cpu_rvalid = r_rd_cpu;
    assign dma_rvalid = r_rd_dma;
    assign cpu_rdata  = r_rd_cpu ? mem_rdata : '0;
    assign dma_rdata  = r_rd_dma ? mem_rdata : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_conflict_cnt <= 16'd0;
        end else if (cpu_req && dma_req && (r_conflict_cnt != c_CONFLICT_MAX)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed and random stimulus for dmem_arbiter, checked against a
//            cycle-level reference model with a behavioural data memory.
// Revision : 1.0 - initial release
// =============================================================================
module tb_dmem_arbiter;

    localparam int W  = 32;
    localparam int MW = 8;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         cpu_req, cpu_we, dma_req, dma_we;
    logic [W-1:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic         cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_write;
    logic [W-1:0] cpu_rdata, dma_rdata, mem_addr, mem_data, mem_rdata;
    logic [15:0]  conflict_cnt;

    always #5 clock = ~clock;

    dmem_arbiter #(.DATA_WIDTH(W), .MAX_WAIT(MW)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    // Data memory: registered address, one-cycle read latency.
    logic [W-1:0] tb_mem [256];
    bit           tb_mem_ready;
    always @(posedge clock) begin
        if (!tb_mem_ready) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= 32'h1000_0000 + 32'(i);
            tb_mem_ready <= 1'b1;
            mem_rdata    <= '0;
        end else begin
            if (mem_write) tb_mem[mem_addr[7:0]] <= mem_data;
            mem_rdata <= tb_mem[mem_addr[7:0]];
        end
    end

    // Reference model state
    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] ref_mem [256];
    int           waited, conflicts;
    bit           pend_cpu, pend_dma;
    logic [W-1:0] pend_cpu_data, pend_dma_data;

    // Observations of the most recent step, for directed constant checks
    logic         last_cpu_gnt, last_dma_gnt, last_cpu_rv, last_dma_rv;
    logic [W-1:0] last_cpu_rd, last_dma_rd;
    logic [15:0]  last_conf;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        waited    = 0;
        conflicts = 0;
        pend_cpu  = 1'b0;
        pend_dma  = 1'b0;
    endtask

    task automatic step(input logic cr, input logic cw, input logic [W-1:0] ca, input logic [W-1:0] cd,
                        input logic dr, input logic dw, input logic [W-1:0] da, input logic [W-1:0] dd);
        bit           promote, eg_c, eg_d, ew;
        logic [W-1:0] ea, ed, ec;
        @(negedge clock);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        #1;
        promote = STARVE && dr && (waited >= MW);
        eg_d    = dr && (promote || !cr);
        eg_c    = cr && !eg_d;
        ew = 1'b0; ea = '0; ed = '0;
        if (eg_c)      begin ea = ca; ed = cd; ew = cw; end
        else if (eg_d) begin ea = da; ed = dd; ew = dw; end
        ec = (conflicts > 65535) ? 32'h0000_FFFF : 32'(conflicts);
        check("cpu_gnt",      cpu_gnt,      eg_c);
        check("dma_gnt",      dma_gnt,      eg_d);
        check("mem_write",    mem_write,    ew);
        check("mem_addr",     mem_addr,     ea);
        check("mem_data",     mem_data,     ed);
        check("cpu_rvalid",   cpu_rvalid,   pend_cpu);
        check("cpu_rdata",    cpu_rdata,    pend_cpu ? pend_cpu_data : '0);
        check("dma_rvalid",   dma_rvalid,   pend_dma);
        check("dma_rdata",    dma_rdata,    pend_dma ? pend_dma_data : '0);
        check("conflict_cnt", conflict_cnt, ec);
        last_cpu_gnt = cpu_gnt;    last_dma_gnt = dma_gnt;
        last_cpu_rv  = cpu_rvalid; last_dma_rv  = dma_rvalid;
        last_cpu_rd  = cpu_rdata;  last_dma_rd  = dma_rdata;
        last_conf    = conflict_cnt;
        @(posedge clock);
        pend_cpu      = eg_c && !cw;
        pend_cpu_data = ref_mem[ca[7:0]];
        pend_dma      = eg_d && !dw;
        pend_dma_data = ref_mem[da[7:0]];
        if (ew) ref_mem[ea[7:0]] = ed;
        if (cr && dr) conflicts++;
        if (dr && !eg_d) waited = (waited < MW) ? waited + 1 : MW;
        else             waited = 0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        int dma_wins;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        check("rst_cpu_rvalid", cpu_rvalid,   '0);
        check("rst_dma_rvalid", dma_rvalid,   '0);
        check("rst_cpu_rdata",  cpu_rdata,    '0);
        check("rst_conflict",   conflict_cnt, '0);
        reset = 1'b0;

        // CPU write then read of address 5
        step(1'b1, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
        check("wr5_gnt", last_cpu_gnt, 1'b1);
        step(1'b1, 1'b0, 32'd5, '0, 1'b0, 1'b0, '0, '0);
        check("rd5_gnt", last_cpu_gnt, 1'b1);
        idle();
        check("rd5_rvalid", last_cpu_rv, 1'b1);
        check("rd5_rdata",  last_cpu_rd, 32'hDEADBEEF);

        // Alternating owners: CPU read 3, then DMA read 7
        step(1'b1, 1'b1, 32'd3, 32'h3333_0003, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'd7, 32'h7777_0007);
        step(1'b1, 1'b0, 32'd3, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'd7, '0);
        check("alt_cpu_rv",  last_cpu_rv, 1'b1);
        check("alt_cpu_rd",  last_cpu_rd, 32'h3333_0003);
        check("alt_dma_rv0", last_dma_rv, 1'b0);
        idle();
        check("alt_dma_rv",  last_dma_rv, 1'b1);
        check("alt_dma_rd",  last_dma_rd, 32'h7777_0007);
        check("alt_cpu_rv0", last_cpu_rv, 1'b0);

        // Continuous contention: promotion every 9th cycle only when enabled
        dma_wins = 0;
        for (int i = 0; i < 27; i++) begin
            step(1'b1, 1'b0, 32'($urandom_range(0, 15)), '0,
                 1'b1, 1'b0, 32'($urandom_range(0, 15)), '0);
            check("starve_pattern", last_dma_gnt, STARVE && (i % 9 == 8));
            if (last_dma_gnt) dma_wins++;
        end
        check("starve_count", 32'(dma_wins), STARVE ? 32'd3 : 32'd0);
        idle();
        idle();

        // Reset asserted during a granted CPU read
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd9;
        #1;
        check("rstmid_gnt", cpu_gnt, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("rstmid_conf", conflict_cnt, '0);
        @(posedge clock);
        @(negedge clock);
        #1;
        check("rstmid_rvalid", cpu_rvalid, '0);
        check("rstmid_rdata",  cpu_rdata,  '0);
        cpu_req = 1'b0;
        reset   = 1'b0;
        model_reset();
        idle();
        check("post_rst_rvalid", last_cpu_rv, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'd7, '0);
        idle();
        check("post_rst_dma_rv", last_dma_rv, 1'b1);
        check("post_rst_dma_rd", last_dma_rd, 32'h7777_0007);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 32'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 3) != 0), 1'($urandom), 32'($urandom_range(0, 15)), $urandom);
        end

        // Drive the conflict counter into saturation
        for (int i = 0; i < 65540; i++) begin
            step(1'b1, 1'($urandom), 32'($urandom_range(0, 15)), $urandom,
                 1'b1, 1'($urandom), 32'($urandom_range(0, 15)), $urandom);
        end
        idle();
        check("conf_saturated", 32'(last_conf), 32'h0000_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, data/address word width; MAX_WAIT, 8, starvation limit in cycles (range 1..255).
REQ-002 Ports SHALL be, in order:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- cpu_req  input  1  CPU access request.
- cpu_we  input  1  CPU write enable.
- cpu_addr  input  DATA_WIDTH  CPU word address.
- cpu_wdata  input  DATA_WIDTH  CPU write data.
- cpu_gnt  output  1  CPU granted this cycle.
- cpu_rvalid  output  1  CPU read data valid.
- cpu_rdata  output  DATA_WIDTH  CPU read data.
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same widths, directions and meanings for the DMA/IO requester.
- mem_addr  output  DATA_WIDTH  address to data memory.
- mem_data  output  DATA_WIDTH  write data to data memory.
- mem_write  output  1  data memory write strobe.
- mem_rdata  input  DATA_WIDTH  data memory read port (registered-address, one-cycle latency).
- conflict_cnt  output  16  saturating count of cycles with both requests high.

Function
REQ-003 cpu_gnt and dma_gnt SHALL be combinational in the same cycle as the request; at most one SHALL be high in any cycle.
REQ-004 Default priority SHALL be CPU: cpu_req high -> cpu_gnt=1, dma_gnt=0; cpu_req low and dma_req high -> dma_gnt=1.
REQ-005 Granted requester's addr/wdata/we SHALL drive mem_addr/mem_data/mem_write combinationally; no grant -> mem_write=0, mem_addr=0, mem_data=0.
REQ-006 A write SHALL complete at the rising edge ending the grant cycle; no rvalid SHALL be produced for writes.
REQ-007 A granted read SHALL register owner (CPU/DMA) at the clock edge; in the next cycle the owner's rvalid SHALL be 1 and its rdata SHALL equal mem_rdata.
REQ-008 rdata of a non-owner or when no read is pending SHALL be 0; rvalid SHALL be a single-cycle pulse per granted read.
REQ-009 Back-to-back reads SHALL be supported with throughput one per cycle, including alternating owners (read CPU cycle N, read DMA cycle N+1 -> cpu_rvalid in N+1, dma_rvalid in N+2).
REQ-010 wait_cnt (8-bit internal) SHALL increment each cycle dma_req=1 and dma_gnt=0, saturating at MAX_WAIT; it SHALL clear when dma_gnt=1 or dma_req=0.
REQ-011 When wait_cnt==MAX_WAIT and dma_req=1, dma_gnt SHALL be 1 and cpu_gnt 0 for that one cycle, regardless of cpu_req (subject to REQ-016).
REQ-012 conflict_cnt SHALL increment on each cycle with cpu_req=1 and dma_req=1, saturating at 16'hFFFF.
REQ-013 A requester whose req drops SHALL lose grant in that same cycle; a pending rvalid for an already-granted read SHALL still be delivered.

Reset
REQ-014 reset SHALL asynchronously clear wait_cnt, read owner, conflict_cnt to 0; while reset high both rvalids SHALL be 0 and rdata 0.
REQ-015 A read granted in the cycle reset asserts SHALL produce no rvalid after reset release; grants SHALL follow REQ-003..005 from the first cycle after release.

Configuration
REQ-016 Macro DMEM_ARB_STARVE_EN: defined -> REQ-010/011 starvation promotion active; undefined -> wait_cnt logic absent, strict CPU priority always, DMA granted only when cpu_req=0.

Verification
REQ-017 Bench SHALL cover:
- CPU write addr 5 data 32'hDEADBEEF, then CPU read addr 5 -> cpu_gnt both cycles, cpu_rvalid next cycle, cpu_rdata=32'hDEADBEEF.
- cpu_req and dma_req high continuously, MAX_WAIT=8, STARVE_EN defined -> dma_gnt exactly every 9th cycle, cpu_gnt the other 8; conflict_cnt increments every cycle.
- Same stimulus, STARVE_EN undefined -> dma_gnt never 1; cpu_gnt always 1.
- CPU read addr 3 cycle N, DMA read addr 7 cycle N+1 -> cpu_rvalid only in N+1 with mem[3], dma_rvalid only in N+2 with mem[7].
- Reset asserted mid-cycle of a granted CPU read -> cpu_rvalid stays 0, conflict_cnt=0, first post-release DMA read returns correct data.
- conflict_cnt preloaded near saturation by 65540 conflict cycles -> holds 16'hFFFF.
